// File: rtl/arrow_player_pkg.sv
// rtl/arrow_player_pkg.sv - direction codes, arrow bit positions and playback states
package arrow_player_pkg;

    // Direction codes shared with the key-select path.
    localparam logic [2:0] DIR_LEFT  = 3'b000;
    localparam logic [2:0] DIR_DOWN  = 3'b001;
    localparam logic [2:0] DIR_UP    = 3'b010;
    localparam logic [2:0] DIR_RIGHT = 3'b011;
    localparam logic [2:0] DIR_NONE  = 3'b111;

    // Bit positions inside the 4-bit one-hot arrow vector {left, right, up, down}.
    localparam int ARW_LEFT  = 3;
    localparam int ARW_RIGHT = 2;
    localparam int ARW_UP    = 1;
    localparam int ARW_DOWN  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHOW  = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/arrow_decode.sv
// rtl/arrow_decode.sv - combinational direction code to one-hot arrow map
//   code   in  3  direction code
//   arrows out 4  {left, right, up, down}; all zero for DIR_NONE and invalid codes
module arrow_decode
    import arrow_player_pkg::*;
(
    input  logic [2:0] code,
    output logic [3:0] arrows
);

    always_comb begin
        arrows = '0;
        case (code)
            DIR_LEFT:  arrows[ARW_LEFT]  = 1'b1;
            DIR_RIGHT: arrows[ARW_RIGHT] = 1'b1;
            DIR_UP:    arrows[ARW_UP]    = 1'b1;
            DIR_DOWN:  arrows[ARW_DOWN]  = 1'b1;
            default:   arrows = '0;
        endcase
    end

endmodule

// File: rtl/arrow_player.sv
// rtl/arrow_player.sv - timed playback of a stored direction sequence as one-hot arrows
//   clock, resetn          clock and asynchronous active-low reset
//   start, seq_len         start pulse and number of steps (sampled on accepted start)
//   rd_addr, rd_data       sequence memory port (1-cycle read latency)
//   arrow_left/right/up/down  registered one-hot arrow outputs
//   busy, done, step_idx   playback status
module arrow_player
    import arrow_player_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int SHOW_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000,
    parameter int CNT_W       = 26
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W:0]   seq_len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_data,
    output logic              arrow_left,
    output logic              arrow_right,
    output logic              arrow_up,
    output logic              arrow_down,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] step_idx
);

    localparam logic [ADDR_W:0]  MAX_STEPS = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  timer, timer_nxt;
    logic [ADDR_W-1:0] step_q, step_nxt;
    logic [ADDR_W-1:0] last_idx, last_nxt;
    logic [3:0]        arrows_q, arrows_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic [3:0]        dec_arrows;
    logic [ADDR_W:0]   len_m1;

    arrow_decode u_decode (
        .code   (rd_data),
        .arrows (dec_arrows)
    );

    // Playback stores the index of the final step; oversize lengths clamp to
    // the last memory address so the read address never wraps.
    assign len_m1 = seq_len - (ADDR_W+1)'(1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            timer    <= '0;
            step_q   <= '0;
            last_idx <= '0;
            arrows_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            step_q   <= step_nxt;
            last_idx <= last_nxt;
            arrows_q <= arrows_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        step_nxt   = step_q;
        last_nxt   = last_idx;
        arrows_nxt = arrows_q;
        busy_nxt   = busy_q;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (seq_len != '0) begin
                        last_nxt  = (seq_len > MAX_STEPS) ? '1 : len_m1[ADDR_W-1:0];
                        step_nxt  = '0;
                        busy_nxt  = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                arrows_nxt = dec_arrows;
                timer_nxt  = SHOW_LOAD;
                state_nxt  = ST_SHOW;
            end
            ST_SHOW: begin
                if (timer == '0) begin
                    arrows_nxt = '0;
                    timer_nxt  = GAP_LOAD;
                    state_nxt  = ST_GAP;
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (timer == '0) begin
                    if (step_q == last_idx) begin
                        // done is registered, so it is high exactly during ST_DONE.
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        step_nxt  = step_q + ADDR_W'(1);
                        state_nxt = ST_FETCH;
                    end
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end
            ST_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The read address always tracks the step being fetched or shown.
    assign rd_addr     = step_q;
    assign step_idx    = step_q;
    assign arrow_left  = arrows_q[ARW_LEFT];
    assign arrow_right = arrows_q[ARW_RIGHT];
    assign arrow_up    = arrows_q[ARW_UP];
    assign arrow_down  = arrows_q[ARW_DOWN];
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_arrow_player.sv
// tb/tb_arrow_player.sv - directed self-checking bench for arrow_player
module tb_arrow_player;

    localparam int ADDR_W = 3;
    localparam int PERIOD = 8;

    logic              clock = 1'b0;
    logic              resetn;
    logic              start;
    logic [ADDR_W:0]   seq_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_data;
    logic              arrow_left, arrow_right, arrow_up, arrow_down;
    logic              busy, done;
    logic [ADDR_W-1:0] step_idx;
    logic [3:0]        arw;

    logic [2:0] mem [0:7];

    int n_checks = 0;
    int n_pass   = 0;
    int onehot_viol = 0;
    int addr_viol   = 0;

    always #5 clock = ~clock;

    arrow_player #(
        .ADDR_W      (ADDR_W),
        .SHOW_CYCLES (4),
        .GAP_CYCLES  (2),
        .CNT_W       (4)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .seq_len     (seq_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .arrow_left  (arrow_left),
        .arrow_right (arrow_right),
        .arrow_up    (arrow_up),
        .arrow_down  (arrow_down),
        .busy        (busy),
        .done        (done),
        .step_idx    (step_idx)
    );

    assign arw = {arrow_left, arrow_right, arrow_up, arrow_down};

    always @(posedge clock) rd_data <= mem[rd_addr];

    always @(negedge clock) begin
        if ($countones(arw) > 1) onehot_viol++;
        if (rd_addr != step_idx) addr_viol++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] exp_dec(input logic [2:0] c);
        case (c)
            3'b000:  return 4'b1000;
            3'b011:  return 4'b0100;
            3'b010:  return 4'b0010;
            3'b001:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // t counts cycles after the start cycle: phase 0 fetch, 1 load, 2..5 show, 6..7 gap.
    function automatic logic [3:0] exp_arrows(input int t, input int n);
        int step, phase;
        if (t < 1) return 4'b0000;
        step  = (t - 1) / PERIOD;
        phase = (t - 1) % PERIOD;
        if (step >= n) return 4'b0000;
        if (phase >= 2 && phase <= 5) return exp_dec(mem[step]);
        return 4'b0000;
    endfunction

    task automatic run_play(input string tag, input int len_in, input int n,
                            input int exp_first, input bit poke);
        int arrow_err = 0, done_cnt = 0, done_t = -1, busy_cyc = 0;
        int max_addr = 0, back = 0, prev_idx = 0, first_t = -1;
        seq_len = len_in[ADDR_W:0];
        start   = 1'b1;
        tick();
        start   = 1'b0;
        seq_len = 4'd1;
        for (int t = 1; t <= PERIOD * n + 4; t++) begin
            if (arw != exp_arrows(t, n)) arrow_err++;
            if (first_t < 0 && arw != 4'b0) first_t = t;
            if (busy) busy_cyc++;
            if (done) begin done_cnt++; done_t = t; end
            if (int'(step_idx) < prev_idx) back++;
            prev_idx = int'(step_idx);
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            start = poke && (t == 5 || t == 20);
            tick();
        end
        start = 1'b0;
        check({tag, "_arrow_err"}, arrow_err, 0);
        check({tag, "_first_arrow_t"}, first_t, exp_first);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_t"}, done_t, PERIOD * n + 1);
        check({tag, "_busy_cycles"}, busy_cyc, PERIOD * n + 1);
        check({tag, "_max_addr"}, max_addr, n - 1);
        check({tag, "_step_back"}, back, 0);
    endtask

    initial begin
        int dcnt;
        resetn  = 1'b0;
        start   = 1'b0;
        seq_len = '0;
        mem[0] = 3'b000; mem[1] = 3'b001; mem[2] = 3'b010; mem[3] = 3'b011;
        mem[4] = 3'b111; mem[5] = 3'b000; mem[6] = 3'b011; mem[7] = 3'b001;
        repeat (3) @(posedge clock);
        #1;
        check("rst_arrows", int'(arw), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_step_idx", int'(step_idx), 0);
        resetn = 1'b1;
        tick();

        // basic: left, down, up, right
        run_play("basic", 4, 4, 3, 1'b0);

        // blank and invalid codes before a right arrow
        mem[0] = 3'b111; mem[1] = 3'b101; mem[2] = 3'b011;
        run_play("blank", 3, 3, 19, 1'b0);

        // zero length
        seq_len = '0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        tick();
        check("zero_done_clr", int'(done), 0);
        check("zero_busy_after", int'(busy), 0);

        // start pulses while busy are ignored
        mem[0] = 3'b000; mem[1] = 3'b001; mem[2] = 3'b010; mem[3] = 3'b011;
        run_play("restart", 4, 4, 3, 1'b1);

        // asynchronous reset during show of step 1
        seq_len = 4'd4;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("mid_arrows_before", int'(arw), 4'b0001);
        check("mid_step_before", int'(step_idx), 1);
        resetn = 1'b0;
        #1;
        check("mid_arrows", int'(arw), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_done", int'(done), 0);
        check("mid_rd_addr", int'(rd_addr), 0);
        check("mid_step_idx", int'(step_idx), 0);
        dcnt = 0;
        repeat (2) begin tick(); if (done) dcnt++; end
        resetn = 1'b1;
        repeat (4) begin tick(); if (done || busy) dcnt++; end
        check("mid_no_done", dcnt, 0);
        run_play("post_rst", 4, 4, 3, 1'b0);

        // saturation: 15 requested, 8 played
        mem[0] = 3'b000; mem[1] = 3'b001; mem[2] = 3'b010; mem[3] = 3'b011;
        mem[4] = 3'b111; mem[5] = 3'b000; mem[6] = 3'b011; mem[7] = 3'b001;
        run_play("sat", 15, 8, 3, 1'b0);

        check("onehot_viol", onehot_viol, 0);
        check("addr_eq_step_viol", addr_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
